// File: rtl/div_sequencer_if.sv
// Handshake/result bundle between the control unit (master) and div_sequencer (slave).
`default_nettype none

interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );
endinterface

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// div_sequencer : multi-cycle signed/unsigned non-restoring divider, 1 bit/clk
// Optional zero-divisor short-cut enabled by macro DIV_ZERO_DETECT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           clear,
    div_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_SIGN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
    logic             dz_q, dz_d;
    logic             dzp_q, dzp_d;
`endif

    logic [WIDTH:0]   w_a_shift;
    logic [WIDTH:0]   w_a_step;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;

    // Add/subtract choice uses the sign of A before the shift; A always lies in [-M, M).
    assign w_a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign w_a_step  = a_q[WIDTH] ? (w_a_shift + {1'b0, m_q}) : (w_a_shift - {1'b0, m_q});
    assign w_dvd_neg = bus.signed_op & bus.dividend[WIDTH-1];
    assign w_dvs_neg = bus.signed_op & bus.divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
    assign w_dvs_mag = w_dvs_neg ? -bus.divisor  : bus.divisor;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= 1'b0;
            dzp_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= dz_d;
            dzp_q   <= dzp_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = dz_q;
        dzp_d   = dzp_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    negq_d  = w_dvd_neg ^ w_dvs_neg;
                    negr_d  = w_dvd_neg;
                    q_d     = w_dvd_mag;
                    m_d     = w_dvs_mag;
                    a_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ITER;
`ifdef DIV_ZERO_DETECT_EN
                    dz_d    = 1'b0;
                    dzp_d   = (bus.divisor == '0);
                    // Zero divisor: park the raw dividend in Q and pass through FIX with A=0.
                    if (bus.divisor == '0) begin
                        q_d     = bus.dividend;
                        negq_d  = 1'b0;
                        negr_d  = 1'b0;
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_ITER: begin
                a_d   = w_a_step;
                q_d   = {q_q[WIDTH-2:0], ~w_a_step[WIDTH]};
                cnt_d = cnt_q + c_CNT_ONE;
                if (cnt_q == c_LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (a_q[WIDTH]) begin
                    a_d = a_q + {1'b0, m_q};
                end
                state_d = S_SIGN;
            end
            S_SIGN: begin
                quot_d  = negq_q ? -q_q : q_q;
                rem_d   = negr_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
                if (dzp_q) begin
                    quot_d = '1;
                    rem_d  = q_q;
                end
                dz_d    = dzp_q;
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_zero  = dz_q;
`else
    assign bus.div_zero  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: arithmetic reference model plus directed cases.
`default_nettype none

module tb_div_sequencer;
    localparam int WIDTH = 32;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif
    localparam int FULL_LAT = WIDTH + 2;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   errors = 0;
    int   checks = 0;

    div_sequencer_if #(.WIDTH(WIDTH)) bus ();
    div_sequencer #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference division on 64-bit magnitudes: truncation toward zero, remainder follows dividend.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint unsigned ma, mb, qq, rr;
        logic na, nb;
        logic [31:0] qv, rv;
        na = s & a[31];
        nb = s & b[31];
        ma = na ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
        mb = nb ? (64'h1_0000_0000 - {32'b0, b}) : {32'b0, b};
        if (mb == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            return;
        end
        qq = ma / mb;
        rr = ma % mb;
        qv = qq[31:0];
        rv = rr[31:0];
        q  = (na ^ nb) ? -qv : qv;
        r  = na ? -rv : rv;
    endfunction

    // ---------------- behavioural model ----------------
    int          m_left  = 0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic        m_dz    = 1'b0;
    logic        m_valid = 1'b1;
    logic [31:0] m_q     = '0;
    logic [31:0] m_r     = '0;
    logic [31:0] p_q, p_r;
    logic        p_dz, p_dc;

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_left  = 0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_dz    = 1'b0;
            m_valid = 1'b1;
            m_q     = '0;
            m_r     = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_dz   = p_dz;
                    m_valid = !p_dc;
                end
            end else if (bus.start) begin
                ref_div(bus.dividend, bus.divisor, bus.signed_op, p_q, p_r);
                p_dz   = DZ_EN && (bus.divisor == 32'd0);
                p_dc   = !DZ_EN && (bus.divisor == 32'd0);
                m_left = p_dz ? 2 : FULL_LAT;
                m_busy = 1'b1;
                m_dz   = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(posedge clock);
            #3;
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("div_zero", 32'(bus.div_zero), 32'(m_dz));
            if (m_valid) begin
                chk("quotient", bus.quotient, m_q);
                chk("remainder", bus.remainder, m_r);
            end
        end
    end

    function automatic logic [31:0] rand_op(input bit is_divisor);
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = is_divisor ? 32'd0 : 32'h8000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3, 4: begin
                v = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Start one divide from the next negedge and wait for done; literal expectations.
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input int exp_lat, input bit chk_vals,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz,
                           input int restart_at);
        int n;
        @(negedge clock);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.signed_op = s;
        @(posedge clock);
        n = 0;
        do begin
            @(negedge clock);
            if (n + 1 == restart_at) begin
                bus.start = 1'b1; bus.dividend = 32'd999; bus.divisor = 32'd3; bus.signed_op = 1'b0;
            end else begin
                bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
            end
            @(posedge clock);
            n++;
            #3;
        end while (!bus.done && n < 60);
        bus.start = 1'b0;
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        if (chk_vals) begin
            chk({name, "_q"}, bus.quotient, eq);
            chk({name, "_r"}, bus.remainder, er);
        end
        chk({name, "_dz"}, 32'(bus.div_zero), 32'(edz));
    endtask

    initial begin : stim
        logic [31:0] tq, tr;
        bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;

        repeat (3) @(posedge clock);
        #3;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q", bus.quotient, 32'd0);
        chk("rst_r", bus.remainder, 32'd0);
        chk("rst_dz", 32'(bus.div_zero), 32'd0);
        @(negedge clock);
        clear = 1'b0;

        ref_div(32'd100, 32'd7, 1'b1, tq, tr);
        chk("model_100_7_q", tq, 32'd14);
        chk("model_100_7_r", tr, 32'd2);
        ref_div(-32'd100, 32'd7, 1'b1, tq, tr);
        chk("model_m100_7_q", tq, 32'hFFFF_FFF2);
        chk("model_m100_7_r", tr, 32'hFFFF_FFFE);
        ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, tq, tr);
        chk("model_ovf_q", tq, 32'h8000_0000);
        chk("model_ovf_r", tr, 32'd0);

        run_div("s100_7",    32'd100,       32'd7,         1'b1, FULL_LAT, 1'b1, 32'd14,        32'd2,         1'b0, -1);
        run_div("sm100_7",   -32'd100,      32'd7,         1'b1, FULL_LAT, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, -1);
        run_div("s100_m7",   32'd100,       -32'd7,        1'b1, FULL_LAT, 1'b1, 32'hFFFF_FFF2, 32'd2,         1'b0, -1);
        run_div("ovf",       32'h8000_0000, 32'hFFFF_FFFF, 1'b1, FULL_LAT, 1'b1, 32'h8000_0000, 32'd0,         1'b0, -1);
        run_div("uFFFF_2",   32'hFFFF_FFFF, 32'd2,         1'b0, FULL_LAT, 1'b1, 32'h7FFF_FFFF, 32'd1,         1'b0, -1);
        run_div("restart",   32'd100,       32'd7,         1'b1, FULL_LAT, 1'b1, 32'd14,        32'd2,         1'b0, 10);
        run_div("zero_div",  32'd55,        32'd0,         1'b1, DZ_EN ? 2 : FULL_LAT, DZ_EN,
                32'hFFFF_FFFF, 32'd55, DZ_EN, -1);
        run_div("after_zero", 32'd81,       32'd9,         1'b0, FULL_LAT, 1'b1, 32'd9,         32'd0,         1'b0, -1);

        // Abort mid-divide with clear.
        @(negedge clock);
        bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.signed_op = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (19) @(negedge clock);
        clear = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_q", bus.quotient, 32'd0);
        chk("abort_r", bus.remainder, 32'd0);
        repeat (2) @(negedge clock);
        clear = 1'b0;
        run_div("post_abort", 32'd1000,     32'd3,         1'b0, FULL_LAT, 1'b1, 32'd333,       32'd1,         1'b0, -1);

        // Randomized traffic, including starts while busy and rare clears.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            clear         = ($urandom_range(0, 1499) == 0);
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.signed_op = $urandom_range(0, 1) == 1;
            bus.dividend  = rand_op(1'b0);
            bus.divisor   = rand_op(1'b1);
        end
        @(negedge clock);
        clear = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(posedge clock);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle signed/unsigned non-restoring divide unit for the CPU's DIV instruction.
- Computes one quotient bit per clock, replacing the single-cycle combinational divider path, so the ALU meets timing.
- Sits between the control unit, which raises `start`, and the HI/LO registers, which are written from `remainder`/`quotient` when `done` is asserted.

Parameters:
- WIDTH, 32, operand and result width in bits; the iteration counter is $clog2(WIDTH) bits.

Ports:
- clock  input  1  system clock, rising-edge active.
- clear  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned; captured with start.
- dividend  input  WIDTH  captured on the accepting edge.
- divisor  input  WIDTH  captured on the accepting edge.
- quotient  output  WIDTH  registered result; holds until the next completion.
- remainder  output  WIDTH  registered result; holds until the next completion.
- busy  output  1  high from the accepting edge until the completion edge.
- done  output  1  one-cycle pulse; results are valid while done=1 and afterwards.
- div_zero  output  1  divisor was zero (optional feature); registered with done.

Behaviour:
- Reset: clock is the single clock; clear is asynchronous and active-high. While clear=1, state=IDLE and quotient, remainder, busy, done, div_zero, the counter and internal A/Q/M are all 0. Assertion mid-operation aborts immediately; no done is produced.
- States: IDLE, ITER, FIX, SIGN.
- IDLE: if start=1 at an edge (E0):
  - record neg_q = signed_op & (dividend[MSB] ^ divisor[MSB]) and neg_r = signed_op & dividend[MSB];
  - load Q = |dividend| and M = |divisor| (magnitudes when signed_op, raw otherwise), A = 0 (WIDTH+1 bits), count = 0;
  - busy<=1, go to ITER.
- ITER, one iteration per edge (E1..E32 for WIDTH=32):
  - {A,Q} shift left 1;
  - if A≥0 then A=A−M, else A=A+M;
  - Q[0] = ~A[MSB];
  - count++; after count reaches WIDTH−1, go to FIX.
- FIX (E33): if A<0, A=A+M; go to SIGN.
- SIGN (E34):
  - quotient <= neg_q ? −Q : Q; remainder <= neg_r ? −A[WIDTH-1:0] : A[WIDTH-1:0];
  - done<=1, busy<=0, go to IDLE.
- Latency: done is high exactly 34 clocks after the accepting edge (WIDTH+2). done deasserts on the next edge.
- Magnitudes are held unsigned, so the most-negative value is valid: its magnitude is 2^(WIDTH−1).
- Overflow: 0x80000000 / −1 (signed) wraps to quotient=0x80000000, remainder=0. No flag is raised.
- Sign convention: quotient truncates toward zero; the remainder takes the dividend's sign.
- start while busy=1 is ignored, with no queueing. start on the same edge done pulses (state=IDLE) is accepted normally.
- Operand inputs may change freely after the accepting edge.

Optional Feature:
- Macro DIV_ZERO_DETECT_EN.
- Defined:
  - a zero divisor seen at the accepting edge skips ITER/FIX;
  - the next edge goes to SIGN, and done rises 2 clocks after acceptance;
  - quotient = all ones, remainder = dividend (unmodified), div_zero = 1 for that result;
  - div_zero is cleared at the next accepting edge.
- Undefined:
  - div_zero is tied 0 and zero divisors run the full 34-cycle sequence;
  - result values are don't-care, and only timing and busy/done behaviour are checked.

Test Plan:
- Signed 100/7: start at E0 → done at E34, quotient=14, remainder=2; busy high E0..E34.
- Signed −100/7 → quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2); signed 100/−7 → quotient=0xFFFFFFF2, remainder=2.
- Signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF/2 → quotient=0x7FFFFFFF, remainder=1.
- Start pulsed again at E10 with different operands → ignored, first result delivered at E34. Back-to-back start on the done cycle → second done 34 clocks later.
- clear asserted at E20 mid-divide → outputs 0 immediately, state IDLE, no done. A new start after release completes normally.
- Divisor 0, dividend 55: with DIV_ZERO_DETECT_EN, done at E2, quotient=0xFFFFFFFF, remainder=55, div_zero=1; without it, done at E34 and div_zero=0.
